// File: rtl/imu_frame_assembler.sv
// Assembles the 14-byte MPU-6050 burst into accel X/Y/Z and gyro X/Y words.
// Define IMU_GYRO_CAL_EN to enable start-up gyro bias estimation and removal.
module imu_frame_assembler #(
  parameter int unsigned FRAME_BYTES    = 14,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CAL_LOG2       = 6
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               frame_start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic signed [15:0] accel_x_raw,
  output logic signed [15:0] accel_y_raw,
  output logic signed [15:0] accel_z_raw,
  output logic signed [15:0] gyro_x_raw,
  output logic signed [15:0] gyro_y_raw,
  output logic               data_ready,
  output logic               frame_err,
  output logic               calib_done
);

  localparam int unsigned IdxW = $clog2(FRAME_BYTES);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  // Word layout and accumulator headroom assume this range.
  if (FRAME_BYTES != 14 || CAL_LOG2 < 1 || CAL_LOG2 > 16 || TIMEOUT_CYCLES < 2)
  begin : g_param_check
    $error("imu_frame_assembler: unsupported parameter values");
  end

  typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              accept, emit, out_en, err_set, frame_err_q, data_ready_q;
  logic [15:0]       ax_q, ay_q, az_q, gx_q, gy_q;
  logic [15:0]       ax_out_q, ay_out_q, az_out_q, gx_out_q, gy_out_q;
  logic [15:0]       gx_corr, gy_corr;

  function automatic logic [15:0] merge_byte(input logic [15:0] w, input logic [7:0] b,
                                             input logic lo);
    return lo ? {w[15:8], b} : {b, w[7:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    err_set    = 1'b0;
    emit       = 1'b0;
    byte_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StCollect;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      StCollect: begin
        byte_ready = ~frame_start;
        if (frame_start) begin
          err_set = (idx_q != '0);
          idx_d   = '0;
          tmo_d   = '0;
        end else if (byte_valid) begin
          tmo_d = '0;
          if (idx_q == IdxW'(FRAME_BYTES - 1)) begin
            state_d = StEmit;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          state_d = StIdle;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StEmit: begin
        emit    = 1'b1;
        state_d = frame_start ? StCollect : StIdle;
        idx_d   = '0;
        tmo_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = byte_valid & byte_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      if (err_set) frame_err_q <= 1'b1;
    end
  end

  // Temperature (word 3) and gyro Z (word 6) bytes are accepted but not stored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ax_q <= '0;
      ay_q <= '0;
      az_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
    end else if (accept) begin
      case (idx_q[IdxW-1:1])
        3'd0:    ax_q <= merge_byte(ax_q, byte_in, idx_q[0]);
        3'd1:    ay_q <= merge_byte(ay_q, byte_in, idx_q[0]);
        3'd2:    az_q <= merge_byte(az_q, byte_in, idx_q[0]);
        3'd4:    gx_q <= merge_byte(gx_q, byte_in, idx_q[0]);
        3'd5:    gy_q <= merge_byte(gy_q, byte_in, idx_q[0]);
        default: ;
      endcase
    end
  end

`ifdef IMU_GYRO_CAL_EN
  logic [CAL_LOG2-1:0] cal_cnt_q;
  logic [31:0]         acc_x_q, acc_y_q, acc_x_nxt, acc_y_nxt;
  logic [15:0]         bias_x_q, bias_y_q;
  logic                calib_done_q;

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7fff;
    return d[15:0];
  endfunction

  assign acc_x_nxt = acc_x_q + {{16{gx_q[15]}}, gx_q};
  assign acc_y_nxt = acc_y_q + {{16{gy_q[15]}}, gy_q};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cal_cnt_q    <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      bias_x_q     <= '0;
      bias_y_q     <= '0;
      calib_done_q <= 1'b0;
    end else if (emit && !calib_done_q) begin
      acc_x_q   <= acc_x_nxt;
      acc_y_q   <= acc_y_nxt;
      cal_cnt_q <= cal_cnt_q + CAL_LOG2'(1);
      if (&cal_cnt_q) begin
        // Low 16 bits of (sum >>> CAL_LOG2); the mean always fits in 16 bits.
        bias_x_q     <= acc_x_nxt[CAL_LOG2 +: 16];
        bias_y_q     <= acc_y_nxt[CAL_LOG2 +: 16];
        calib_done_q <= 1'b1;
      end
    end
  end

  assign gx_corr    = sat_sub(gx_q, bias_x_q);
  assign gy_corr    = sat_sub(gy_q, bias_y_q);
  assign out_en     = emit & calib_done_q;
  assign calib_done = calib_done_q;
`else
  assign gx_corr    = gx_q;
  assign gy_corr    = gy_q;
  assign out_en     = emit;
  assign calib_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ax_out_q     <= '0;
      ay_out_q     <= '0;
      az_out_q     <= '0;
      gx_out_q     <= '0;
      gy_out_q     <= '0;
      data_ready_q <= 1'b0;
    end else begin
      data_ready_q <= out_en;
      if (out_en) begin
        ax_out_q <= ax_q;
        ay_out_q <= ay_q;
        az_out_q <= az_q;
        gx_out_q <= gx_corr;
        gy_out_q <= gy_corr;
      end
    end
  end

  assign accel_x_raw = ax_out_q;
  assign accel_y_raw = ay_out_q;
  assign accel_z_raw = az_out_q;
  assign gyro_x_raw  = gx_out_q;
  assign gyro_y_raw  = gy_out_q;
  assign data_ready  = data_ready_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Directed bench for imu_frame_assembler; the calibration flow runs when IMU_GYRO_CAL_EN is set.
module tb_imu_frame_assembler;

  localparam int unsigned Tmo = 4096;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               frame_start;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic signed [15:0] accel_x_raw, accel_y_raw, accel_z_raw, gyro_x_raw, gyro_y_raw;
  logic               data_ready, frame_err, calib_done;

  int n_checks = 0;
  int n_pass   = 0;
  int dr_cnt   = 0;
  int d0;
  logic [7:0] fr [14];

  always #5 clk = ~clk;

  imu_frame_assembler #(
    .FRAME_BYTES   (14),
    .TIMEOUT_CYCLES(Tmo),
    .CAL_LOG2      (2)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .frame_start(frame_start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .accel_x_raw(accel_x_raw),
    .accel_y_raw(accel_y_raw),
    .accel_z_raw(accel_z_raw),
    .gyro_x_raw (gyro_x_raw),
    .gyro_y_raw (gyro_y_raw),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .calib_done (calib_done)
  );

  always @(negedge clk) if (data_ready) dr_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [111:0] v);
    for (int i = 0; i < 14; i++) fr[i] = v[111-8*i -: 8];
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        byte_valid = 1'b0;
        tick();
      end
      byte_in    = fr[i];
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ax, input logic [15:0] ay,
                            input logic [15:0] az, input logic [15:0] gx,
                            input logic [15:0] gy);
    check({tag, "_ax"}, accel_x_raw, ax);
    check({tag, "_ay"}, accel_y_raw, ay);
    check({tag, "_az"}, accel_z_raw, az);
    check({tag, "_gx"}, gyro_x_raw, gx);
    check({tag, "_gy"}, gyro_y_raw, gy);
  endtask

  // Called right after the final byte's accepting edge.
  task automatic expect_emit(input string tag, input logic [15:0] ax, input logic [15:0] ay,
                             input logic [15:0] az, input logic [15:0] gx,
                             input logic [15:0] gy);
    check({tag, "_dr_early"}, {15'd0, data_ready}, 16'd0);
    tick();
    check({tag, "_dr"}, {15'd0, data_ready}, 16'd1);
    check_outs(tag, ax, ay, az, gx, gy);
    tick();
    check({tag, "_dr_pulse"}, {15'd0, data_ready}, 16'd0);
  endtask

  initial begin
    n_rst       = 1'b0;
    frame_start = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    tick();
    tick();
    check_outs("rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("rst_dr", {15'd0, data_ready}, 16'd0);
    check("rst_err", {15'd0, frame_err}, 16'd0);
    check("rst_rdy", {15'd0, byte_ready}, 16'd0);
    n_rst = 1'b1;
    tick();

`ifdef IMU_GYRO_CAL_EN
    check("rst_cal", {15'd0, calib_done}, 16'd0);
    set_frame(112'h0102_FF38_4000_0000_0064_FFF9_1234);
    d0 = dr_cnt;
    for (int k = 0; k < 4; k++) begin
      start();
      send_bytes(14, 1'b0);
      tick();
      check($sformatf("cal%0d_done", k), {15'd0, calib_done}, (k == 3) ? 16'd1 : 16'd0);
    end
    tick();
    check("cal_no_dr", 16'(dr_cnt - d0), 16'd0);
    check_outs("cal_hold", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    set_frame(112'h0102_FF38_4000_0000_8000_FFF9_1234);
    start();
    send_bytes(14, 1'b0);
    expect_emit("cal_sat", 16'h0102, 16'hFF38, 16'h4000, 16'h8000, 16'h0000);
    set_frame(112'h0001_0002_0003_0000_00C8_0000_0000);
    start();
    send_bytes(14, 1'b0);
    expect_emit("cal_sub", 16'h0001, 16'h0002, 16'h0003, 16'h0064, 16'h0007);
`else
    check("rst_cal", {15'd0, calib_done}, 16'd1);

    // Basic frame; the second start arrives at index 0 and must not flag an error.
    set_frame(112'h0102_FF38_4000_0000_0010_FFF0_1234);
    d0 = dr_cnt;
    start();
    start();
    send_bytes(14, 1'b0);
    expect_emit("basic", 16'h0102, 16'hFF38, 16'h4000, 16'h0010, 16'hFFF0);
    check("basic_err", {15'd0, frame_err}, 16'd0);
    check("basic_cnt", 16'(dr_cnt - d0), 16'd1);

    // byte_valid toggled every other cycle
    d0 = dr_cnt;
    start();
    send_bytes(14, 1'b1);
    check("gap_no_early", 16'(dr_cnt - d0), 16'd0);
    expect_emit("gap", 16'h0102, 16'hFF38, 16'h4000, 16'h0010, 16'hFFF0);
    check("gap_cnt", 16'(dr_cnt - d0), 16'd1);

    // Restart after 5 bytes
    d0 = dr_cnt;
    start();
    send_bytes(5, 1'b0);
    set_frame({14{8'h11}});
    start();
    check("rs_err", {15'd0, frame_err}, 16'd1);
    send_bytes(14, 1'b0);
    expect_emit("rs", 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111);
    check("rs_cnt", 16'(dr_cnt - d0), 16'd1);

    // Timeout after 3 bytes, from a fresh reset
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("to_rst_err", {15'd0, frame_err}, 16'd0);
    set_frame(112'h0102_FF38_4000_0000_0010_FFF0_1234);
    d0 = dr_cnt;
    start();
    send_bytes(3, 1'b0);
    repeat (Tmo - 1) tick();
    check("to_early_err", {15'd0, frame_err}, 16'd0);
    check("to_early_rdy", {15'd0, byte_ready}, 16'd1);
    tick();
    check("to_err", {15'd0, frame_err}, 16'd1);
    check("to_idle_rdy", {15'd0, byte_ready}, 16'd0);
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    tick();
    tick();
    byte_valid = 1'b0;
    check("to_no_dr", 16'(dr_cnt - d0), 16'd0);
    check_outs("to_hold", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    start();
    send_bytes(14, 1'b0);
    expect_emit("to_next", 16'h0102, 16'hFF38, 16'h4000, 16'h0010, 16'hFFF0);

    // Reset mid-frame at byte 9
    set_frame({14{8'hAA}});
    start();
    send_bytes(9, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check_outs("mrst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("mrst_dr", {15'd0, data_ready}, 16'd0);
    check("mrst_err", {15'd0, frame_err}, 16'd0);
    check("mrst_rdy", {15'd0, byte_ready}, 16'd0);
    tick();
    n_rst = 1'b1;
    tick();
    set_frame(112'h7FFF_8000_0000_0000_8000_0001_AABB);
    start();
    send_bytes(14, 1'b0);
    expect_emit("clean", 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
